// File: rtl/vga_pkg.sv
// Shared constants for the key-driven picture positioner: default limits,
// key indices, debouncer state encoding and the saturating axis step.
package vga_pkg;

  localparam int DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int DEF_X_LIMIT         = 320;
  localparam int DEF_Y_LIMIT         = 120;

  localparam int KEY_RIGHT = 0;
  localparam int KEY_LEFT  = 1;
  localparam int KEY_DOWN  = 2;
  localparam int KEY_UP    = 3;

  localparam logic [0:0] DB_STABLE   = 1'b0;
  localparam logic [0:0] DB_COUNTING = 1'b1;

  typedef logic signed [15:0] offset_t;

  // The increment key wins outright; when it is blocked at the limit, the
  // decrement key is deliberately not consulted.
  function automatic offset_t step_axis(input offset_t off, input logic inc,
                                        input logic dec, input offset_t lim);
    offset_t res;
    res = off;
    if (inc) begin
      if (off < lim) res = off + 16'sd1;
    end else if (dec) begin
      if (off > -lim) res = off - 16'sd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One pushbutton: 2-flop synchronizer followed by a STABLE/COUNTING
// debouncer that accepts a new level after DEBOUNCE_CYCLES stable samples.
module key_debounce
  import vga_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clock_50,
  input  logic reset_n,
  input  logic key_raw,
  output logic pressed
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_reg;
  logic [0:0]       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             level_reg, level_next;
  logic             key_sync;

  assign key_sync = sync_reg[1];

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    level_next = level_reg;
    case (state_reg)
      DB_STABLE: begin
        cnt_next = '0;
        if (key_sync != level_reg) state_next = DB_COUNTING;
      end
      default: begin
        if (key_sync == level_reg) begin
          state_next = DB_STABLE;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          level_next = key_sync;
          cnt_next   = '0;
          state_next = DB_STABLE;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
    endcase
  end

  // Raw keys idle high, so the synchronizer and accepted level reset released.
  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      sync_reg  <= 2'b11;
      state_reg <= DB_STABLE;
      cnt_reg   <= '0;
      level_reg <= 1'b1;
    end else begin
      sync_reg  <= {sync_reg[0], key_raw};
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      level_reg <= level_next;
    end
  end

  assign pressed = ~level_reg;

endmodule

// File: rtl/key_pos_ctrl.sv
// Moves a picture offset by one pixel per frame while debounced keys are held,
// clamping each axis at its configured +/- limit.
module key_pos_ctrl
  import vga_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int X_LIMIT         = DEF_X_LIMIT,
  parameter int Y_LIMIT         = DEF_Y_LIMIT
) (
  input  logic        clock_50,
  input  logic        reset_n,
  input  logic        k0,
  input  logic        k1,
  input  logic        k2,
  input  logic        k3,
  input  logic        vert_sync,
  output logic [3:0]  key_down,
  output logic [15:0] x_off,
  output logic [15:0] y_off,
  output logic        frame_tick
);

  localparam offset_t X_LIM = offset_t'(X_LIMIT);
  localparam offset_t Y_LIM = offset_t'(Y_LIMIT);

  logic [3:0] keys_raw;
  logic [3:0] key_down_w;
  logic [1:0] vs_sync_reg;
  logic       vs_prev_reg;
  logic       tick_reg;
  offset_t    x_off_reg, x_off_next;
  offset_t    y_off_reg, y_off_next;

  assign keys_raw = {k3, k2, k1, k0};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_key
      key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .clock_50(clock_50),
        .reset_n (reset_n),
        .key_raw (keys_raw[gi]),
        .pressed (key_down_w[gi])
      );
    end
  endgenerate

  // Tick fires once per synchronized rising edge, however long vert_sync stays high.
  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      vs_sync_reg <= 2'b00;
      vs_prev_reg <= 1'b0;
      tick_reg    <= 1'b0;
    end else begin
      vs_sync_reg <= {vs_sync_reg[0], vert_sync};
      vs_prev_reg <= vs_sync_reg[1];
      tick_reg    <= vs_sync_reg[1] & ~vs_prev_reg;
    end
  end

  always_comb begin
    x_off_next = x_off_reg;
    y_off_next = y_off_reg;
    if (tick_reg) begin
      x_off_next = step_axis(x_off_reg, key_down_w[KEY_RIGHT], key_down_w[KEY_LEFT], X_LIM);
      y_off_next = step_axis(y_off_reg, key_down_w[KEY_DOWN], key_down_w[KEY_UP], Y_LIM);
    end
  end

  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      x_off_reg <= '0;
      y_off_reg <= '0;
    end else begin
      x_off_reg <= x_off_next;
      y_off_reg <= y_off_next;
    end
  end

  assign key_down   = key_down_w;
  assign x_off      = x_off_reg;
  assign y_off      = y_off_reg;
  assign frame_tick = tick_reg;

endmodule

// File: tb/tb_key_pos_ctrl.sv
// Directed bench for key_pos_ctrl with a short debounce window.
module tb_key_pos_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  keys;
  logic        vert_sync;
  logic [3:0]  key_down;
  logic [15:0] x_off;
  logic [15:0] y_off;
  logic        frame_tick;

  int n_vec = 0;
  int n_err = 0;
  int tick_cnt = 0;

  key_pos_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .X_LIMIT(320),
    .Y_LIMIT(120)
  ) dut (
    .clock_50  (clk),
    .reset_n   (reset_n),
    .k0        (keys[0]),
    .k1        (keys[1]),
    .k2        (keys[2]),
    .k3        (keys[3]),
    .vert_sync (vert_sync),
    .key_down  (key_down),
    .x_off     (x_off),
    .y_off     (y_off),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_tick) tick_cnt = tick_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      vert_sync = 1'b1;
      wait_cycles(2);
      vert_sync = 1'b0;
      wait_cycles(6);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [3:0] kd_seen;
    reset_n   = 1'b0;
    keys      = 4'hF;
    vert_sync = 1'b0;
    wait_cycles(3);
    chk("rst_x", x_off, 16'h0000);
    chk("rst_y", y_off, 16'h0000);
    chk("rst_tick", frame_tick, 1'b0);
    chk("rst_keys", key_down, 4'b0000);
    reset_n = 1'b1;
    wait_cycles(2);

    // k0 held, ten frames
    keys = 4'b1110;
    wait_cycles(20);
    chk("k0_down", key_down, 4'b0001);
    tick_cnt = 0;
    pulses(10);
    chk("k0_x10", x_off, 16'd10);
    chk("k0_y0", y_off, 16'd0);
    chk("k0_ticks", tick_cnt, 32'd10);

    // bouncing k0 must never be accepted
    do_reset();
    keys = 4'hF;
    kd_seen = 4'b0000;
    for (int i = 0; i < 20; i++) begin
      keys[0] = ~keys[0];
      @(negedge clk); kd_seen |= key_down;
      @(negedge clk); kd_seen |= key_down;
    end
    wait_cycles(20);
    chk("bounce_seen", kd_seen, 4'b0000);
    pulses(3);
    chk("bounce_x", x_off, 16'd0);

    // k1 held into the left clamp
    keys = 4'b1101;
    wait_cycles(20);
    chk("k1_down", key_down, 4'b0010);
    pulses(5);
    chk("k1_x_m5", x_off, 16'hFFFB);
    pulses(325);
    chk("k1_x_sat", x_off, 16'hFEC0);

    // k0 from -320 to the right clamp
    keys = 4'b1110;
    wait_cycles(20);
    pulses(640);
    chk("k0_x_sat", x_off, 16'h0140);

    // k0+k1: blocked right must not fall through to left
    keys = 4'b1100;
    wait_cycles(20);
    chk("k01_down", key_down, 4'b0011);
    pulses(5);
    chk("k01_x_hold", x_off, 16'h0140);

    // all keys: y climbs to +120 while x stays clamped
    keys = 4'b0000;
    wait_cycles(20);
    pulses(125);
    chk("k23_y_sat", y_off, 16'h0078);
    chk("k23_x_hold", x_off, 16'h0140);

    // k3 alone moves up
    keys = 4'b0111;
    wait_cycles(20);
    pulses(3);
    chk("k3_y", y_off, 16'h0075);
    chk("k3_x", x_off, 16'h0140);

    // reset mid-count
    do_reset();
    keys = 4'b1110;
    wait_cycles(20);
    pulses(7);
    chk("pre_rst_x", x_off, 16'd7);
    keys = 4'hF;
    wait_cycles(2);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("mid_rst_x", x_off, 16'd0);
    chk("mid_rst_keys", key_down, 4'b0000);
    keys = 4'b1110;
    wait_cycles(20);
    chk("no_sync_x", x_off, 16'd0);
    chk("no_sync_keys", key_down, 4'b0001);
    pulses(1);
    chk("post_rst_x", x_off, 16'd1);

    // vert_sync held high: latency and single tick
    tick_cnt = 0;
    @(negedge clk);
    vert_sync = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("lat_tick_e2", frame_tick, 1'b0);
    @(posedge clk);
    #1 chk("lat_tick_e3", frame_tick, 1'b1);
    chk("lat_x_e3", x_off, 16'd1);
    @(posedge clk);
    #1 chk("lat_x_e4", x_off, 16'd2);
    wait_cycles(96);
    chk("held_ticks", tick_cnt, 32'd1);
    chk("held_x", x_off, 16'd2);
    vert_sync = 1'b0;
    wait_cycles(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
